fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares one FIFO write interface among NUM_REQ requesters in a single clock domain. Each requester presents a valid/ready stream. The arbiter grants one owner at a time, holds the grant for a bounded burst, and drives the FIFO's data_in/write_en while honouring fifo_full. It sits directly in front of the FIFO write port, on the write clock.

---
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Define FIFO_WR_ARB_BURST_EN to hold a grant for up to MAX_BURST accepts; otherwise one accept per grant.
module fifo_wr_arbiter #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 8,
   parameter  int MAX_BURST  = 4,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic                          fifo_write_en,
   output logic                          grant_valid,
   output logic [ID_W-1:0]               grant_id
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [ID_W-1:0] grant_id_q, grant_id_d;
   logic [ID_W-1:0] last_id_q, last_id_d;

   logic            owner_valid;
   logic            accept;
   logic            burst_last;
   logic            grant_release;

   logic [ID_W-1:0] search_base;
   logic [ID_W-1:0] cand;
   logic [ID_W-1:0] winner;
   logic            found;

   // Explicit wrap keeps non-power-of-2 NUM_REQ from ever indexing past the last requester.
   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      if (id == ID_W'(NUM_REQ - 1)) begin
         return '0;
      end
      return id + 1'b1;
   endfunction

   // Search starts just after the pointer, so the previous owner is considered last.
   // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      search_base = next_id((state_q == S_IDLE) ? last_id_q : grant_id_q);
      found       = 1'b0;
      winner      = '0;
      cand        = search_base;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
         cand = next_id(cand);
      end
   end

   always_comb begin
      owner_valid   = req_valid[grant_id_q];
      accept        = (state_q == S_GRANT) && owner_valid && !fifo_full;
      req_ready     = '0;
      fifo_data_in  = '0;
      fifo_write_en = accept;
      grant_valid   = (state_q == S_GRANT);
      grant_id      = grant_id_q;
      if (state_q == S_GRANT) begin
         req_ready[grant_id_q] = !fifo_full;
         fifo_data_in          = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

`ifdef FIFO_WR_ARB_BURST_EN
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

   assign burst_last = (burst_cnt_q == CNT_W'(MAX_BURST - 1));

   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (state_q == S_IDLE || grant_release) begin
         burst_cnt_d = '0;
      end else if (accept) begin
         burst_cnt_d = burst_cnt_q + 1'b1;
      end
   end
`else
   assign burst_last = 1'b1;
`endif

   assign grant_release = (state_q == S_GRANT) && (!owner_valid || (accept && burst_last));

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      last_id_d  = last_id_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d    = S_GRANT;
               grant_id_d = winner;
            end
         end
         S_GRANT: begin
            // Handoff goes straight to the next winner so there is no idle bubble.
            if (grant_release) begin
               last_id_d = grant_id_q;
               if (found) begin
                  grant_id_d = winner;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every one updates from the same pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         grant_id_q  <= '0;
         last_id_q   <= ID_W'(NUM_REQ - 1);
`ifdef FIFO_WR_ARB_BURST_EN
         burst_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         last_id_q   <= last_id_d;
`ifdef FIFO_WR_ARB_BURST_EN
         burst_cnt_q <= burst_cnt_d;
`endif
      end
   end

endmodule
